// File: rtl/snes_vector_detect_pkg.sv
// Shared definitions for the SNES vector-fetch detector: default vector addresses,
// the bank-mirroring compare mask, FSM state encoding and the masked address compare.
package snes_vector_detect_pkg;

  localparam logic [23:0] RST_VEC_DEF   = 24'h00FFFC;
  localparam logic [23:0] NMI_VEC_DEF   = 24'h00FFEA;
  // Only bank bit 22 is compared, so banks 00-3F and 80-BF alias each other.
  localparam logic [23:0] ADDR_MASK_DEF = 24'h40FFFF;

  // One-hot detector states.
  typedef enum logic [3:0] {
    StIdle     = 4'b0001,
    StRstLo    = 4'b0010,
    StNmiLo    = 4'b0100,
    StHookPend = 4'b1000
  } vec_state_e;

  function automatic logic addr_match(input logic [23:0] addr, input logic [23:0] vec,
                                      input logic [23:0] mask);
    return ((addr ^ vec) & mask) == 24'h000000;
  endfunction

endpackage

// File: rtl/snes_vector_detect.sv
// Detects CPU reset/NMI vector fetches (low byte then high byte within a cycle window),
// pulses hit strobes, keeps a saturating NMI count and holds a hook request after an
// armed reset-vector fetch until the consumer acknowledges it.
module snes_vector_detect
  import snes_vector_detect_pkg::*;
#(
  parameter logic [23:0] RST_VEC   = RST_VEC_DEF,
  parameter logic [23:0] NMI_VEC   = NMI_VEC_DEF,
  parameter logic [23:0] ADDR_MASK = ADDR_MASK_DEF,
  parameter int unsigned WINDOW    = 16,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_event_latch,
  input  logic [23:0]      i_addr,
  input  logic             i_arm,
  input  logic             i_hook_ack,
  input  logic             i_cnt_clr,
  output logic             o_rst_hit,
  output logic             o_nmi_hit,
  output logic             o_hook_req,
  output logic [CNT_W-1:0] o_nmi_count
);

  localparam int unsigned   TW       = $clog2(WINDOW + 1);
  localparam logic [TW-1:0] WIN_LOAD = TW'(WINDOW);
  localparam logic [23:0]   RST_HI   = RST_VEC + 24'd1;
  localparam logic [23:0]   NMI_HI   = NMI_VEC + 24'd1;

  vec_state_e        r_state, w_state_d;
  logic [TW-1:0]     r_timer, w_timer_d;
  logic              r_rst_hit, w_rst_hit_d;
  logic              r_nmi_hit, w_nmi_hit_d;
  logic [CNT_W-1:0]  r_nmi_count;

  logic w_m_rst_lo, w_m_rst_hi, w_m_nmi_lo, w_m_nmi_hi;

  assign w_m_rst_lo = i_event_latch & addr_match(i_addr, RST_VEC, ADDR_MASK);
  assign w_m_rst_hi = i_event_latch & addr_match(i_addr, RST_HI, ADDR_MASK);
  assign w_m_nmi_lo = i_event_latch & addr_match(i_addr, NMI_VEC, ADDR_MASK);
  assign w_m_nmi_hi = i_event_latch & addr_match(i_addr, NMI_HI, ADDR_MASK);

  // Next state, window timer and hit strobes; an event in the expiry cycle beats the timeout.
  always_comb begin
    w_state_d   = r_state;
    w_timer_d   = r_timer;
    w_rst_hit_d = 1'b0;
    w_nmi_hit_d = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_m_rst_lo) begin
          w_state_d = StRstLo;
          w_timer_d = WIN_LOAD;
        end else if (w_m_nmi_lo) begin
          w_state_d = StNmiLo;
          w_timer_d = WIN_LOAD;
        end
      end
      StRstLo, StNmiLo: begin
        w_timer_d = r_timer - TW'(1);
        if ((r_state == StRstLo) && w_m_rst_hi) begin
          w_rst_hit_d = 1'b1;
          w_state_d   = i_arm ? StHookPend : StIdle;
          w_timer_d   = '0;
        end else if ((r_state == StNmiLo) && w_m_nmi_hi) begin
          w_nmi_hit_d = 1'b1;
          w_state_d   = StIdle;
          w_timer_d   = '0;
        end else if (w_m_rst_lo) begin
          w_state_d = StRstLo;
          w_timer_d = WIN_LOAD;
        end else if (w_m_nmi_lo) begin
          w_state_d = StNmiLo;
          w_timer_d = WIN_LOAD;
        end else if (i_event_latch || (r_timer <= TW'(1))) begin
          // Unrelated fetch or window expired: the partial pair is dropped.
          w_state_d = StIdle;
          w_timer_d = '0;
        end
      end
      StHookPend: begin
        if (i_hook_ack) begin
          w_state_d = StIdle;
        end
      end
      default: begin
        w_state_d = StIdle;
        w_timer_d = '0;
      end
    endcase
  end

  // State, timer and hit strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_timer   <= '0;
      r_rst_hit <= 1'b0;
      r_nmi_hit <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_timer   <= w_timer_d;
      r_rst_hit <= w_rst_hit_d;
      r_nmi_hit <= w_nmi_hit_d;
    end
  end

  // Saturating NMI counter; advances while nmi_hit is high, clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nmi_count <= '0;
    end else if (i_cnt_clr) begin
      r_nmi_count <= '0;
    end else if (r_nmi_hit && (r_nmi_count != '1)) begin
      r_nmi_count <= r_nmi_count + CNT_W'(1);
    end
  end

  assign o_rst_hit   = r_rst_hit;
  assign o_nmi_hit   = r_nmi_hit;
  assign o_hook_req  = (r_state == StHookPend);
  assign o_nmi_count = r_nmi_count;

endmodule

// File: tb/tb_snes_vector_detect.sv
// Self-checking bench for snes_vector_detect: directed scenarios plus random traffic,
// compared every cycle against a pair/window model expressed in cycle distances.
module tb_snes_vector_detect;

  localparam logic [23:0] RST_LO  = 24'h00FFFC;
  localparam logic [23:0] NMI_LO  = 24'h00FFEA;
  localparam logic [23:0] MASK    = 24'h40FFFF;
  localparam int          WINDOW  = 16;
  localparam int          CNT_W   = 8;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             i_event_latch = 1'b0;
  logic [23:0]      i_addr = '0;
  logic             i_arm = 1'b0;
  logic             i_hook_ack = 1'b0;
  logic             i_cnt_clr = 1'b0;
  logic             o_rst_hit, o_nmi_hit, o_hook_req;
  logic [CNT_W-1:0] o_nmi_count;

  int checks = 0;
  int failures = 0;

  // Reference model state: pending low-byte kind (0 none, 1 reset, 2 NMI) and its cycle.
  int m_pend = 0;
  int m_pend_cyc = 0;
  int m_cyc = 0;
  bit m_hooked = 1'b0;
  int m_cnt = 0;
  bit exp_rst = 1'b0;
  bit exp_nmi = 1'b0;
  int rst_hits = 0;
  int nmi_hits = 0;

  snes_vector_detect #(
    .WINDOW(WINDOW),
    .CNT_W (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_event_latch(i_event_latch),
    .i_addr       (i_addr),
    .i_arm        (i_arm),
    .i_hook_ack   (i_hook_ack),
    .i_cnt_clr    (i_cnt_clr),
    .o_rst_hit    (o_rst_hit),
    .o_nmi_hit    (o_nmi_hit),
    .o_hook_req   (o_hook_req),
    .o_nmi_count  (o_nmi_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".rst_hit"}, 32'(o_rst_hit), 32'(exp_rst));
    check({tag, ".nmi_hit"}, 32'(o_nmi_hit), 32'(exp_nmi));
    check({tag, ".hook_req"}, 32'(o_hook_req), 32'(m_hooked));
    check({tag, ".nmi_count"}, 32'(o_nmi_count), 32'(m_cnt));
  endtask

  // One clock cycle of stimulus, model update and output check.
  task automatic step(input bit ev, input logic [23:0] a, input bit arm, input bit ack,
                      input bit clr, input string tag);
    bit n_rst = 1'b0;
    bit n_nmi = 1'b0;
    logic [23:0] am;
    @(negedge clk);
    i_event_latch = ev;
    i_addr        = a;
    i_arm         = arm;
    i_hook_ack    = ack;
    i_cnt_clr     = clr;
    am = a & MASK;
    if (clr) m_cnt = 0;
    else if (exp_nmi && m_cnt != CNT_MAX) m_cnt++;
    if (m_hooked) begin
      if (ack) m_hooked = 1'b0;
    end else if (ev) begin
      if (m_pend == 1 && (m_cyc - m_pend_cyc) <= WINDOW && am == ((RST_LO + 24'd1) & MASK)) begin
        n_rst = 1'b1;
        m_pend = 0;
        if (arm) m_hooked = 1'b1;
      end else if (m_pend == 2 && (m_cyc - m_pend_cyc) <= WINDOW &&
                   am == ((NMI_LO + 24'd1) & MASK)) begin
        n_nmi = 1'b1;
        m_pend = 0;
      end else if (am == (RST_LO & MASK)) begin
        m_pend = 1;
        m_pend_cyc = m_cyc;
      end else if (am == (NMI_LO & MASK)) begin
        m_pend = 2;
        m_pend_cyc = m_cyc;
      end else begin
        m_pend = 0;
      end
    end
    m_cyc++;
    @(posedge clk);
    #1;
    exp_rst = n_rst;
    exp_nmi = n_nmi;
    if (n_rst) rst_hits++;
    if (n_nmi) nmi_hits++;
    check_all(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 24'h0, 1'b0, 1'b0, 1'b0, tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    i_event_latch = 1'b0;
    i_hook_ack = 1'b0;
    i_cnt_clr = 1'b0;
    #1;
    m_pend = 0;
    m_hooked = 1'b0;
    m_cnt = 0;
    exp_rst = 1'b0;
    exp_nmi = 1'b0;
    check_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [23:0] rand_addr();
    logic [23:0] base;
    logic [23:0] mir;
    mir = 24'($urandom) & ~MASK;
    case ($urandom_range(0, 5))
      0: base = RST_LO;
      1: base = RST_LO + 24'd1;
      2: base = NMI_LO;
      3: base = NMI_LO + 24'd1;
      4: return 24'($urandom);
      default: base = 24'h00FFFE;
    endcase
    return (base & MASK) | mir;
  endfunction

  initial begin
    int hits_before;
    // Reset state
    #1;
    check_all("reset0");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1: armed reset-vector pair -> hit and held hook until ack
    step(1'b1, 24'h00FFFC, 1'b1, 1'b0, 1'b0, "t1.lo");
    idle(2, "t1.gap");
    step(1'b1, 24'h00FFFD, 1'b1, 1'b0, 1'b0, "t1.hi");
    check("t1.hit", 32'(o_rst_hit), 32'd1);
    step(1'b0, 24'h0, 1'b0, 1'b0, 1'b0, "t1.held");
    check("t1.pulse_end", 32'(o_rst_hit), 32'd0);
    step(1'b1, 24'h00FFEA, 1'b0, 1'b0, 1'b0, "t1.ign_lo");
    step(1'b1, 24'h00FFEB, 1'b0, 1'b0, 1'b0, "t1.ign_hi");
    check("t1.hook_held", 32'(o_hook_req), 32'd1);
    step(1'b0, 24'h0, 1'b0, 1'b1, 1'b0, "t1.ack");
    check("t1.hook_drop", 32'(o_hook_req), 32'd0);

    // 2: disarmed reset-vector pair -> hit, no hook
    step(1'b1, 24'h00FFFC, 1'b0, 1'b0, 1'b0, "t2.lo");
    idle(2, "t2.gap");
    step(1'b1, 24'h00FFFD, 1'b0, 1'b0, 1'b0, "t2.hi");
    check("t2.hit", 32'(o_rst_hit), 32'd1);
    check("t2.nohook", 32'(o_hook_req), 32'd0);
    step(1'b0, 24'h0, 1'b1, 1'b1, 1'b0, "t2.stray_ack");

    // 3: 300 mirrored NMI pairs -> count saturates
    hits_before = nmi_hits;
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 24'h80FFEA, 1'b0, 1'b0, 1'b0, "t3.lo");
      step(1'b1, 24'h80FFEB, 1'b0, 1'b0, 1'b0, "t3.hi");
      step(1'b0, 24'h0, 1'b0, 1'b0, 1'b0, "t3.gap");
    end
    check("t3.pulses", 32'(nmi_hits - hits_before), 32'd300);
    check("t3.sat", 32'(o_nmi_count), 32'(CNT_MAX));

    // 4: window boundary (distance WINDOW hits, WINDOW+1 and beyond do not)
    step(1'b1, 24'h00FFFC, 1'b0, 1'b0, 1'b0, "t4.lo_a");
    idle(WINDOW + 1, "t4.gap_a");
    step(1'b1, 24'h00FFFD, 1'b0, 1'b0, 1'b0, "t4.late");
    check("t4.nohit_late", 32'(o_rst_hit), 32'd0);
    step(1'b1, 24'h00FFFC, 1'b0, 1'b0, 1'b0, "t4.lo_b");
    idle(WINDOW, "t4.gap_b");
    step(1'b1, 24'h00FFFD, 1'b0, 1'b0, 1'b0, "t4.just_late");
    check("t4.nohit_edge", 32'(o_rst_hit), 32'd0);
    step(1'b1, 24'h00FFFC, 1'b0, 1'b0, 1'b0, "t4.lo_c");
    idle(WINDOW - 1, "t4.gap_c");
    step(1'b1, 24'h00FFFD, 1'b0, 1'b0, 1'b0, "t4.in_time");
    check("t4.hit_edge", 32'(o_rst_hit), 32'd1);

    // 5: interrupted pair, then reset-lo superseded by an NMI pair
    step(1'b1, 24'h00FFFC, 1'b0, 1'b0, 1'b0, "t5.lo");
    step(1'b1, 24'h001234, 1'b0, 1'b0, 1'b0, "t5.other");
    step(1'b1, 24'h00FFFD, 1'b0, 1'b0, 1'b0, "t5.hi");
    check("t5.nohit", 32'(o_rst_hit), 32'd0);
    step(1'b1, 24'h00FFFC, 1'b0, 1'b0, 1'b0, "t5.rlo");
    step(1'b1, 24'h00FFEA, 1'b0, 1'b0, 1'b0, "t5.nlo");
    step(1'b1, 24'h00FFEB, 1'b0, 1'b0, 1'b0, "t5.nhi");
    check("t5.nmi_only", 32'({o_rst_hit, o_nmi_hit}), 32'b01);

    // 6: reset mid-pair discards it; clear coincident with nmi_hit wins
    step(1'b1, 24'h00FFFC, 1'b1, 1'b0, 1'b0, "t6.lo");
    do_reset("t6.rst");
    step(1'b1, 24'h00FFFD, 1'b1, 1'b0, 1'b0, "t6.hi");
    check("t6.nohit", 32'(o_rst_hit), 32'd0);
    step(1'b1, 24'h00FFEA, 1'b0, 1'b0, 1'b0, "t6.nlo");
    step(1'b1, 24'h00FFEB, 1'b0, 1'b0, 1'b0, "t6.nhi");
    step(1'b0, 24'h0, 1'b0, 1'b0, 1'b1, "t6.clr");
    check("t6.clr_wins", 32'(o_nmi_count), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) idle($urandom_range(WINDOW - 2, WINDOW + 2), "rnd.gap");
      step($urandom_range(0, 2) != 0, rand_addr(), 1'($urandom), $urandom_range(0, 3) == 0,
           $urandom_range(0, 59) == 0, "rnd");
    end
    check("rnd.some_hits", 32'((rst_hits > 5) && (nmi_hits > 305)), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
